// File: rtl/mem_sched_pkg.sv
// Shared defaults, request record and pointer helper for the memory port scheduler.
package mem_sched_pkg;

  localparam int NREQ_DEF = 4;
  localparam int AW_DEF   = 4;
  localparam int DW_DEF   = 4;
  localparam int IDW      = $clog2(NREQ_DEF);

  // One requester's command as seen at the default geometry.
  typedef struct packed {
    logic              write;
    logic [AW_DEF-1:0] addr;
    logic [DW_DEF-1:0] wdata;
  } req_t;

  // Round-robin successor; wraps at n-1 so non-power-of-2 counts work.
  function automatic int unsigned wrap_inc(input int unsigned x, input int unsigned n);
    return (x + 1 >= n) ? 0 : x + 1;
  endfunction

endpackage

// File: rtl/mem_port_scheduler_rr_pick.sv
// Rotating-priority picker: first set bit of req at or after start, wrapping mod N.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic          hit,
  output logic [IW-1:0] idx
);

  // Walk the ring from the far end back toward start so the closest hit wins.
  always_comb begin
    int          j;
    logic [IW-1:0] jj;
    hit = 1'b0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(start) + k;
      if (j >= N) j = j - N;
      jj = IW'(j);
      if (req[jj]) begin
        hit = 1'b1;
        idx = jj;
      end
    end
  end

endmodule

// File: rtl/mem_port_scheduler.sv
// Shares a 2-write/1-read register file between NREQ requesters with
// round-robin grants, avoiding same-address write pairs and read/write collisions.
module mem_port_scheduler
  import mem_sched_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF,
  localparam int IW  = $clog2(NREQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req_valid,
  input  logic [NREQ-1:0]  req_write,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]  req_ready,
  output logic             mem_we1,
  output logic             mem_we2,
  output logic [AW-1:0]    mem_wa1,
  output logic [AW-1:0]    mem_wa2,
  output logic [DW-1:0]    mem_wd1,
  output logic [DW-1:0]    mem_wd2,
  output logic             mem_re,
  output logic [AW-1:0]    mem_ra,
  input  logic [DW-1:0]    mem_rd,
  output logic             rsp_valid,
  output logic [IW-1:0]    rsp_id,
  output logic [DW-1:0]    rsp_data
);

  logic [NREQ-1:0][AW-1:0] addr;
  logic [NREQ-1:0][DW-1:0] wdata;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign addr[i]  = req_addr[i*AW +: AW];
    assign wdata[i] = req_wdata[i*DW +: DW];
  end

  logic [IW-1:0]   wr_ptr, rd_ptr;
  logic [IW-1:0]   w1_idx, w2_idx, rd_idx;
  logic            w1_hit, w2_hit, rd_hit;
  logic [NREQ-1:0] wmask, w2mask, rmask;
  logic            rsp_vld_q;

  // Reset masks every candidate, so all grants and memory strobes fall to 0.
  assign wmask = rst ? '0 : (req_valid & req_write);

  // Port-2 candidates: other writers whose address differs from port 1
  // (this also drops the port-1 winner itself).
  always_comb begin
    w2mask = '0;
    for (int i = 0; i < NREQ; i++)
      w2mask[i] = wmask[i] && (addr[i] != addr[w1_idx]);
  end

  // Read candidates: any reader not hitting an address written this cycle.
  always_comb begin
    rmask = '0;
    for (int i = 0; i < NREQ; i++)
      rmask[i] = !rst && req_valid[i] && !req_write[i]
                 && !(w1_hit && addr[i] == addr[w1_idx])
                 && !(w2_hit && addr[i] == addr[w2_idx]);
  end

  // Port 2 scans from the same pointer; port 1's winner is the first in that
  // order, so the next remaining hit is the next writer in ring order.
  rr_pick #(.N(NREQ), .IW(IW)) u_pick_w1 (.req(wmask),  .start(wr_ptr), .hit(w1_hit), .idx(w1_idx));
  rr_pick #(.N(NREQ), .IW(IW)) u_pick_w2 (.req(w2mask), .start(wr_ptr), .hit(w2_hit), .idx(w2_idx));
  rr_pick #(.N(NREQ), .IW(IW)) u_pick_rd (.req(rmask),  .start(rd_ptr), .hit(rd_hit), .idx(rd_idx));

  assign mem_we1 = w1_hit;
  assign mem_wa1 = w1_hit ? addr[w1_idx]  : '0;
  assign mem_wd1 = w1_hit ? wdata[w1_idx] : '0;
  assign mem_we2 = w2_hit;
  assign mem_wa2 = w2_hit ? addr[w2_idx]  : '0;
  assign mem_wd2 = w2_hit ? wdata[w2_idx] : '0;
  assign mem_re  = rd_hit;
  assign mem_ra  = rd_hit ? addr[rd_idx]  : '0;

  // Ready mirrors the grants; the three winners are always distinct requesters.
  always_comb begin
    req_ready = '0;
    if (w1_hit) req_ready[w1_idx] = 1'b1;
    if (w2_hit) req_ready[w2_idx] = 1'b1;
    if (rd_hit) req_ready[rd_idx] = 1'b1;
  end

  // Advance pointers past the last winner of each kind; track the read in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      rsp_vld_q <= 1'b0;
      rsp_id    <= '0;
    end else begin
      if (w2_hit)
        wr_ptr <= IW'(wrap_inc(32'(w2_idx), NREQ));
      else if (w1_hit)
        wr_ptr <= IW'(wrap_inc(32'(w1_idx), NREQ));
      if (rd_hit) begin
        rd_ptr <= IW'(wrap_inc(32'(rd_idx), NREQ));
        rsp_id <= rd_idx;
      end
      rsp_vld_q <= rd_hit;
    end
  end

  // A read granted just before reset must not surface while reset is high.
  assign rsp_valid = rsp_vld_q && !rst;
  assign rsp_data  = mem_rd;

endmodule

// File: tb/tb_mem_port_scheduler.sv
// Scoreboard bench: a ring-order reference decides grants and read data,
// a separate monitor checks every response against the queued expectation.
module tb_mem_port_scheduler;
  import mem_sched_pkg::*;

  localparam int N  = 4;
  localparam int AW = 4;
  localparam int DW = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0]    req_valid = '0, req_write = '0, req_ready;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic mem_we1, mem_we2, mem_re;
  logic [AW-1:0] mem_wa1, mem_wa2, mem_ra;
  logic [DW-1:0] mem_wd1, mem_wd2, mem_rd;
  logic rsp_valid;
  logic [IW-1:0] rsp_id;
  logic [DW-1:0] rsp_data;

  always #5 clk = ~clk;

  mem_port_scheduler #(.NREQ(N), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready),
    .mem_we1(mem_we1), .mem_we2(mem_we2), .mem_wa1(mem_wa1), .mem_wa2(mem_wa2),
    .mem_wd1(mem_wd1), .mem_wd2(mem_wd2), .mem_re(mem_re), .mem_ra(mem_ra), .mem_rd(mem_rd),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data)
  );

  // Register-file stand-in: writes and registered read at the clock edge.
  logic [DW-1:0] ram [16];
  always @(posedge clk) begin
    if (mem_we1) ram[mem_wa1] <= mem_wd1;
    if (mem_we2) ram[mem_wa2] <= mem_wd2;
    if (mem_re)  mem_rd <= ram[mem_ra];
  end

  typedef struct { int cyc; int id; logic [DW-1:0] data; bit known; } exp_t;

  exp_t          expq[$];
  int            n_cmp = 0, n_err = 0, cyc = 0;
  bit            in_rst = 1'b1;
  bit            pv [N];
  req_t          pr [N];
  logic [DW-1:0] gmem [16];
  bit            gknown [16];
  int            mptr_w = 0, mptr_r = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic set_req(input int i, input int w, input int a, input int d);
    pv[i]       = 1'b1;
    pr[i].write = w[0];
    pr[i].addr  = a[AW-1:0];
    pr[i].wdata = d[DW-1:0];
  endtask

  task automatic drive_ports();
    for (int i = 0; i < N; i++) begin
      req_valid[i]            = pv[i];
      req_write[i]            = pr[i].write;
      req_addr[i*AW +: AW]    = pr[i].addr;
      req_wdata[i*DW +: DW]   = pr[i].wdata;
    end
  endtask

  // One cycle: present requests, predict the grants from ring order, compare, update model.
  task automatic step();
    int w1, w2, rd, i;
    logic [N-1:0] er;
    logic [AW-1:0] ea1, ea2, era;
    logic [DW-1:0] ed1, ed2;
    exp_t e;
    drive_ports();
    #1;
    w1 = -1; w2 = -1; rd = -1;
    for (int k = 0; k < N; k++) begin
      i = (mptr_w + k) % N;
      if (pv[i] && pr[i].write) begin
        if (w1 < 0) w1 = i;
        else if (w2 < 0 && pr[i].addr != pr[w1].addr) w2 = i;
      end
    end
    for (int k = 0; k < N; k++) begin
      i = (mptr_r + k) % N;
      if (rd < 0 && pv[i] && !pr[i].write
          && !(w1 >= 0 && pr[i].addr == pr[w1].addr)
          && !(w2 >= 0 && pr[i].addr == pr[w2].addr)) rd = i;
    end
    er = '0; ea1 = '0; ea2 = '0; era = '0; ed1 = '0; ed2 = '0;
    if (w1 >= 0) begin er[w1] = 1'b1; ea1 = pr[w1].addr; ed1 = pr[w1].wdata; end
    if (w2 >= 0) begin er[w2] = 1'b1; ea2 = pr[w2].addr; ed2 = pr[w2].wdata; end
    if (rd >= 0) begin er[rd] = 1'b1; era = pr[rd].addr; end
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("mem_we1", 32'(mem_we1), 32'(w1 >= 0));
    chk("mem_wa1", 32'(mem_wa1), 32'(ea1));
    chk("mem_wd1", 32'(mem_wd1), 32'(ed1));
    chk("mem_we2", 32'(mem_we2), 32'(w2 >= 0));
    chk("mem_wa2", 32'(mem_wa2), 32'(ea2));
    chk("mem_wd2", 32'(mem_wd2), 32'(ed2));
    chk("mem_re", 32'(mem_re), 32'(rd >= 0));
    chk("mem_ra", 32'(mem_ra), 32'(era));
    if (rd >= 0) begin
      e.cyc = cyc + 1; e.id = rd; e.data = gmem[pr[rd].addr]; e.known = gknown[pr[rd].addr];
      expq.push_back(e);
      mptr_r = (rd + 1) % N;
      pv[rd] = 1'b0;
    end
    if (w1 >= 0) begin
      gmem[pr[w1].addr] = pr[w1].wdata; gknown[pr[w1].addr] = 1'b1;
      mptr_w = (w1 + 1) % N; pv[w1] = 1'b0;
    end
    if (w2 >= 0) begin
      gmem[pr[w2].addr] = pr[w2].wdata; gknown[pr[w2].addr] = 1'b1;
      mptr_w = (w2 + 1) % N; pv[w2] = 1'b0;
    end
    @(posedge clk); cyc++;
    @(negedge clk);
  endtask

  // Two reset cycles with whatever requests are pending left on the bus.
  task automatic do_reset();
    in_rst = 1'b1;
    expq.delete();
    rst = 1'b1;
    drive_ports();
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_strobes", 32'({mem_we1, mem_we2, mem_re}), 32'd0);
      chk("rst_addr_data", 32'({mem_wa1, mem_wa2, mem_ra, mem_wd1, mem_wd2}), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      @(posedge clk); cyc++;
      @(negedge clk);
    end
    rst = 1'b0;
    mptr_w = 0; mptr_r = 0;
    in_rst = 1'b0;
  endtask

  // Response monitor, decoupled from stimulus.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #2;
      if (!in_rst) begin
        if (rsp_valid) begin
          if (expq.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL rsp_unexpected at cycle %0d: got id %0d, expected no response", cyc, rsp_id);
          end else begin
            e = expq.pop_front();
            chk("rsp_latency", 32'(cyc), 32'(e.cyc));
            chk("rsp_id", 32'(rsp_id), 32'(e.id));
            if (e.known) chk("rsp_data", 32'(rsp_data), 32'(e.data));
          end
        end else if (expq.size() > 0 && expq[0].cyc <= cyc) begin
          e = expq.pop_front();
          n_cmp++; n_err++;
          $display("FAIL rsp_missing at cycle %0d: got none, expected id %0d", cyc, e.id);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < N; i++) begin pv[i] = 1'b0; pr[i] = '0; end
    for (int a = 0; a < 16; a++) begin gmem[a] = '0; gknown[a] = 1'b0; end
    @(negedge clk);
    do_reset();

    // write then read back
    set_req(0, 1, 3, 'hA); step();
    set_req(1, 0, 3, 0);   step(); step();

    // two distinct-address writes in one cycle
    do_reset();
    set_req(0, 1, 1, 'h5); set_req(2, 1, 2, 'h6); step();
    set_req(1, 0, 1, 0); step();
    set_req(3, 0, 2, 0); step(); step();

    // same-address write pair is split across cycles
    do_reset();
    set_req(1, 1, 7, 'h1); set_req(3, 1, 7, 'h2); step(); step();
    set_req(0, 0, 7, 0); step(); step();

    // read deferred behind a colliding write
    do_reset();
    set_req(0, 1, 4, 'hC); set_req(1, 0, 4, 0); step(); step(); step();

    // all requesters streaming writes to distinct addresses
    do_reset();
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++) if (!pv[i]) set_req(i, 1, 8 + i, $urandom_range(0, 15));
      step();
    end
    for (int r = 0; r < 3; r++) step();

    // read granted, then reset the very next cycle
    set_req(1, 0, 3, 0); step();
    do_reset();
    set_req(0, 1, 5, 'h9); set_req(2, 1, 6, 'h3); step(); step();

    // randomized traffic with a narrow address range to force collisions
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++)
        if (!pv[i] && $urandom_range(0, 1) == 1)
          set_req(i, int'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 15)));
      if ($urandom_range(0, 149) == 0) do_reset();
      else step();
    end

    // drain outstanding requests and responses
    for (int c = 0; c < 20; c++) step();
    #3;
    chk("drain_queue_empty", 32'(expq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_scheduler.md
Name: mem_port_scheduler

Overview:
- Arbiter/scheduler that shares one 2-write/1-read register-file memory (16 x 4 by default) between NREQ requesters.
- Each cycle it grants up to two writes and one read, using round-robin priority.
- It never issues a same-address write pair, and never a read colliding with a same-cycle write. Both cases are architecturally undefined or priority-dependent on the memory.
- Sits between client logic and the memory instance; returns read data tagged with requester id.

Parameters:
- NREQ, 4, number of requesters (2..8).
- AW, 4, memory address width.
- DW, 4, memory data width.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  request pending, per requester.
- req_write  in  NREQ  1 = write, 0 = read.
- req_addr  in  NREQ*AW  request address, requester i at [i*AW +: AW].
- req_wdata  in  NREQ*DW  write data, same packing.
- req_ready  out  NREQ  request accepted this cycle (combinational).
- mem_we1, mem_we2  out  1  memory write enables, ports 1/2.
- mem_wa1, mem_wa2  out  AW  write addresses.
- mem_wd1, mem_wd2  out  DW  write data.
- mem_re  out  1  memory read enable.
- mem_ra  out  AW  read address.
- mem_rd  in  DW  registered read data from the memory, valid one cycle after mem_re.
- rsp_valid  out  1  read response valid.
- rsp_id  out  $clog2(NREQ)  requester that issued the read.
- rsp_data  out  DW  read data; equals mem_rd.

Behaviour:
- Handshake:
  - A request transfers when req_valid[i] && req_ready[i].
  - Requester holds valid/write/addr/wdata stable until ready.
  - Responses cannot be back-pressured.
- State: wr_ptr and rd_ptr (round-robin pointers, $clog2(NREQ) bits), rsp_valid, rsp_id.
- Write grant (combinational):
  - Scan requesters in order wr_ptr, wr_ptr+1, ... mod NREQ, over valid&write.
  - First hit goes to port 1.
  - Next hit whose addr differs from the port-1 addr goes to port 2.
  - A same-address hit is skipped and stays pending.
- Read grant:
  - Scan from rd_ptr over valid&!write.
  - First hit whose addr matches neither granted write addr goes to the read port.
  - A blocked read does not block later eligible reads.
- Memory outputs:
  - mem_we1/mem_we2/mem_re are 1 only for granted slots.
  - Unused address/data outputs are driven 0.
  - Outputs are combinational in the grant cycle; the memory samples them at the next edge.
- req_ready[i] = 1 exactly for granted requesters. At most 3 ready per cycle, max one per requester.
- Pointer update on a clock edge with grants:
  - wr_ptr <= (index of last granted write + 1) mod NREQ.
  - rd_ptr <= (read index + 1) mod NREQ.
  - Unchanged when there is no grant of that kind.
- Read response:
  - rsp_valid <= mem_re and rsp_id <= granted read index, both registered.
  - Latency is exactly 1 cycle after the grant cycle.
  - rsp_data = mem_rd, meaningful only while rsp_valid.
- A read deferred by a collision is granted no earlier than the next cycle and returns the newly written data.
- Reset:
  - While rst = 1: req_ready = 0, mem_we1/mem_we2/mem_re = 0, all addr/data outputs 0.
  - Next edge: wr_ptr = 0, rd_ptr = 0, rsp_valid = 0, rsp_id = 0.
  - A read granted in the cycle before reset asserts produces no response.
- Memory contents are not cleared by reset.
- NREQ non-power-of-2: pointers wrap at NREQ-1 back to 0.

Decomposition:
- Package mem_sched_pkg holds:
  - defaults for NREQ/AW/DW;
  - IDW = $clog2(NREQ);
  - a request struct {write, addr, wdata}.
- One natural sub-module, rr_pick: rotating-priority picker with inputs req mask and start pointer; outputs hit, index.
- rr_pick is instantiated three times: port-1 write, port-2 write (mask excludes the first pick and same-address requests), and read (mask excludes colliding addresses).

Test Plan:
- Req0 writes addr 3 = 0xA; next cycle req1 reads addr 3 -> req_ready[1] = 1; one cycle later rsp_valid = 1, rsp_id = 1, rsp_data = 0xA.
- Req0 writes addr 1 = 0x5 and req2 writes addr 2 = 0x6 in the same cycle, wr_ptr = 0 -> both ready; mem_we1/wa1 = 1/1, mem_we2/wa2 = 1/2; later reads return 0x5 and 0x6.
- Req1 and req3 both write addr 7 (0x1, 0x2), wr_ptr = 0 -> only req1 ready in cycle 0, req3 ready in cycle 1; subsequent read of addr 7 returns 0x2.
- Req0 writes addr 4 = 0xC while req1 reads addr 4 -> write granted, mem_re = 0 that cycle; read granted next cycle; rsp_data = 0xC.
- All 4 requesters issue back-to-back writes to distinct addresses -> grant pairs (0,1), (2,3), (0,1) ...; no requester waits more than 2 cycles.
- Read granted, rst asserted the following cycle -> rsp_valid = 0 and req_ready = 0 during reset; after release, first write grant goes to req0 (wr_ptr = 0).
